// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, register ids, status codes, ifun limits) and
// the instruction-length helpers used by fetch and decode.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] FN_CMOV_MAX = 4'd6;
    localparam logic [3:0] FN_JXX_MAX  = 4'd6;
    localparam logic [3:0] FN_OPQ_MAX  = 4'd3;

    function automatic logic need_regids(input logic [3:0] ic);
        return (ic == IRRMOVQ) || (ic == IIRMOVQ) || (ic == IRMMOVQ) ||
               (ic == IMRMOVQ) || (ic == IOPQ)    || (ic == IPUSHQ)  ||
               (ic == IPOPQ);
    endfunction

    function automatic logic need_valc(input logic [3:0] ic);
        return (ic == IIRMOVQ) || (ic == IRMMOVQ) || (ic == IMRMOVQ) ||
               (ic == IJXX)    || (ic == ICALL);
    endfunction

    function automatic logic instr_valid(input logic [3:0] ic, input logic [3:0] fn);
        logic ok;
        ok = 1'b0;
        if (ic <= IPOPQ) begin
            case (ic)
                IRRMOVQ: ok = (fn <= FN_CMOV_MAX);
                IJXX:    ok = (fn <= FN_JXX_MAX);
                IOPQ:    ok = (fn <= FN_OPQ_MAX);
                default: ok = (fn == 4'h0);
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/y86_seq_fetch_if.sv
// Fetch-stage bus: next-PC and program-load inputs, split instruction and
// status outputs towards decode.
interface y86_seq_fetch_if;
    logic [63:0] pc_next;
    logic        load_en;
    logic [63:0] load_addr;
    logic [7:0]  load_data;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    modport master (
        output pc_next, load_en, load_addr, load_data,
        input  pc, icode, ifun, rA, rB, valC, valP, stat, halted, retired
    );

    modport slave (
        input  pc_next, load_en, load_addr, load_data,
        output pc, icode, ifun, rA, rB, valC, valP, stat, halted, retired
    );
endinterface

// File: rtl/y86_imem.sv
// Byte-addressed instruction memory: synchronous byte write, combinational
// 10-byte read window at rd_addr with per-byte out-of-range flags.
module y86_imem #(
    parameter int IMEM_BYTES = 4096
) (
    input  logic             clk,
    input  logic [63:0]      rd_addr,
    output logic [9:0][7:0]  rd_bytes,
    output logic [9:0]       rd_oor,
    input  logic             wr_en,
    input  logic [63:0]      wr_addr,
    input  logic [7:0]       wr_dat
);
    localparam int AW = $clog2(IMEM_BYTES);

    logic [7:0] mem [IMEM_BYTES];
    logic       base_ok;
    logic [AW:0] byte_addr [10];

    // Offsets are added in AW+1 bits so crossing the top of memory shows up
    // as a carry instead of wrapping back to address 0.
    always_comb begin
        base_ok = (rd_addr < 64'(IMEM_BYTES));
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = {1'b0, rd_addr[AW-1:0]} + (AW+1)'(i);
            rd_oor[i]    = !base_ok || byte_addr[i][AW];
            rd_bytes[i]  = rd_oor[i] ? 8'h00 : mem[byte_addr[i][AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < 64'(IMEM_BYTES)))
            mem[wr_addr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/y86_seq_fetch.sv
// SEQ fetch stage: PC, status and retire registers plus combinational split.
// Latency 0 from pc to outputs; no backpressure, machine freezes when stat != AOK.
module y86_seq_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 4096,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    y86_seq_fetch_if.slave    bus
);
    logic [63:0]     pc_q;
    logic [2:0]      stat_q;
    logic [63:0]     retired_q;

    logic [9:0][7:0] win;
    logic [9:0]      oor;
    logic [3:0]      raw_icode;
    logic [3:0]      raw_ifun;
    logic            nr;
    logic            nc;
    logic [3:0]      len;
    logic [9:0]      len_mask;
    logic            imem_error;
    logic            valid;
    logic [2:0]      f_stat;
    logic            halted;
    logic            bubble;
    logic [63:0]     raw_valc;

    y86_imem #(.IMEM_BYTES(IMEM_BYTES)) u_imem (
        .clk      (clk),
        .rd_addr  (pc_q),
        .rd_bytes (win),
        .rd_oor   (oor),
        .wr_en    (bus.load_en),
        .wr_addr  (bus.load_addr),
        .wr_dat   (bus.load_data)
    );

    always_comb begin
        raw_icode  = win[0][7:4];
        raw_ifun   = win[0][3:0];
        nr         = need_regids(raw_icode);
        nc         = need_valc(raw_icode);
        len        = 4'd1 + {3'b0, nr} + {nc, 3'b000};
        len_mask   = (10'b1 << len) - 10'b1;
        imem_error = |(oor & len_mask);
        valid      = instr_valid(raw_icode, raw_ifun);
        raw_valc   = nr ? win[9:2] : win[8:1];

        if (imem_error)             f_stat = SADR;
        else if (!valid)            f_stat = SINS;
        else if (raw_icode == IHALT) f_stat = SHLT;
        else                        f_stat = SAOK;

        halted = (stat_q != SAOK);
        bubble = halted || (f_stat == SADR) || (f_stat == SINS);
    end

    // Bubbled outputs look like a nop with no register fields, so decode and
    // write-back stay idle while the machine is stopped or faulting.
    always_comb begin
        bus.pc      = pc_q;
        bus.stat    = stat_q;
        bus.halted  = halted;
        bus.retired = retired_q;
        bus.icode   = INOP;
        bus.ifun    = 4'h0;
        bus.rA      = RNONE;
        bus.rB      = RNONE;
        bus.valC    = 64'h0;
        bus.valP    = pc_q;
        if (!bubble) begin
            bus.icode = raw_icode;
            bus.ifun  = raw_ifun;
            bus.rA    = nr ? win[1][7:4] : RNONE;
            bus.rB    = nr ? win[1][3:0] : RNONE;
            bus.valC  = nc ? raw_valc : 64'h0;
            bus.valP  = pc_q + 64'(len);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            stat_q    <= SAOK;
            retired_q <= 64'h0;
        end else if (stat_q == SAOK) begin
            stat_q <= f_stat;
            if (f_stat == SAOK) begin
                pc_q      <= bus.pc_next;
                retired_q <= retired_q + 64'h1;
            end
        end
    end

endmodule

// File: tb/tb_y86_seq_fetch.sv
// Directed-vector bench for the SEQ fetch stage with hand-computed expectations.
module tb_y86_seq_fetch;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    y86_seq_fetch_if bus ();

    y86_seq_fetch #(.IMEM_BYTES(4096), .RESET_PC(64'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_byte(input logic [63:0] addr, input logic [7:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(posedge clk);
        #1;
        bus.load_en   = 1'b0;
    endtask

    task automatic step(input logic [63:0] nxt);
        bus.pc_next = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] prog_irmov [10];

    initial begin
        rst           = 1'b1;
        bus.pc_next   = 64'h0;
        bus.load_en   = 1'b0;
        bus.load_addr = 64'h0;
        bus.load_data = 8'h00;
        prog_irmov    = '{8'h30, 8'hF3, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        // Program loads happen with reset held so the PC stays put.
        for (int a = 0; a < 4096; a++) load_byte(64'(a), 8'h00);
        for (int i = 0; i < 10; i++) load_byte(64'(i), prog_irmov[i]);
        load_byte(64'd10, 8'h21); load_byte(64'd11, 8'h45);
        load_byte(64'd12, 8'h60); load_byte(64'd13, 8'h01);
        load_byte(64'd14, 8'h63); load_byte(64'd15, 8'h23);
        load_byte(64'd16, 8'h10);
        load_byte(64'h40, 8'hC0);
        load_byte(64'h50, 8'h27);
        load_byte(64'd4090, 8'h30);
        load_byte(64'd4094, 8'h20); load_byte(64'd4095, 8'h12);
        load_byte(64'd4096, 8'hC0);
        rst = 1'b0;
        #1;

        check_eq("reset_pc", bus.pc, 64'h0);
        check_eq("reset_stat", 64'(bus.stat), 64'd1);
        check_eq("reset_retired", bus.retired, 64'd0);
        check_eq("reset_halted", 64'(bus.halted), 64'd0);

        check_eq("irmov_icode", 64'(bus.icode), 64'h3);
        check_eq("irmov_ifun", 64'(bus.ifun), 64'h0);
        check_eq("irmov_rA", 64'(bus.rA), 64'hF);
        check_eq("irmov_rB", 64'(bus.rB), 64'h3);
        check_eq("irmov_valC", bus.valC, 64'h1122334455667788);
        check_eq("irmov_valP", bus.valP, 64'd10);
        step(64'd10);
        check_eq("irmov_pc", bus.pc, 64'd10);
        check_eq("irmov_retired", bus.retired, 64'd1);

        check_eq("cmov_icode", 64'(bus.icode), 64'h2);
        check_eq("cmov_ifun", 64'(bus.ifun), 64'h1);
        check_eq("cmov_rA", 64'(bus.rA), 64'h4);
        check_eq("cmov_rB", 64'(bus.rB), 64'h5);
        check_eq("cmov_valC", bus.valC, 64'h0);
        check_eq("cmov_valP", bus.valP, 64'd12);
        step(64'd12);
        check_eq("opq_icode", 64'(bus.icode), 64'h6);
        check_eq("opq_ifun", 64'(bus.ifun), 64'h0);
        check_eq("opq_rA", 64'(bus.rA), 64'h0);
        check_eq("opq_rB", 64'(bus.rB), 64'h1);
        check_eq("opq_valP", bus.valP, 64'd14);
        step(64'd14);
        check_eq("xorq_ifun", 64'(bus.ifun), 64'h3);
        check_eq("xorq_valP", bus.valP, 64'd16);
        step(64'd16);
        check_eq("xorq_stat", 64'(bus.stat), 64'd1);
        check_eq("nop_icode", 64'(bus.icode), 64'h1);
        check_eq("nop_rA", 64'(bus.rA), 64'hF);
        check_eq("nop_valP", bus.valP, 64'd17);
        step(64'h20);
        check_eq("halt_pc", bus.pc, 64'h20);
        check_eq("halt_retired_pre", bus.retired, 64'd5);
        check_eq("halt_icode", 64'(bus.icode), 64'h0);
        check_eq("halt_valP", bus.valP, 64'h21);
        check_eq("halt_stat_pre", 64'(bus.stat), 64'd1);
        step(64'h99);
        check_eq("halt_stat", 64'(bus.stat), 64'd2);
        check_eq("halt_halted", 64'(bus.halted), 64'd1);
        check_eq("halt_bubble_icode", 64'(bus.icode), 64'h1);
        check_eq("halt_bubble_valP", bus.valP, 64'h20);
        for (int k = 0; k < 5; k++) step(64'h99);
        check_eq("halt_pc_frozen", bus.pc, 64'h20);
        check_eq("halt_retired_frozen", bus.retired, 64'd5);
        check_eq("halt_stat_frozen", 64'(bus.stat), 64'd2);

        pulse_reset();
        step(64'h40);
        check_eq("ins_c0_pc", bus.pc, 64'h40);
        check_eq("ins_c0_icode", 64'(bus.icode), 64'h1);
        check_eq("ins_c0_rA", 64'(bus.rA), 64'hF);
        check_eq("ins_c0_rB", 64'(bus.rB), 64'hF);
        check_eq("ins_c0_valP", bus.valP, 64'h40);
        step(64'h0);
        check_eq("ins_c0_stat", 64'(bus.stat), 64'd4);
        check_eq("ins_c0_retired", bus.retired, 64'd1);

        pulse_reset();
        step(64'h50);
        check_eq("ins_27_icode", 64'(bus.icode), 64'h1);
        check_eq("ins_27_rB", 64'(bus.rB), 64'hF);
        step(64'h0);
        check_eq("ins_27_stat", 64'(bus.stat), 64'd4);

        pulse_reset();
        step(64'd4090);
        check_eq("adr_pc", bus.pc, 64'd4090);
        check_eq("adr_icode", 64'(bus.icode), 64'h1);
        check_eq("adr_valC", bus.valC, 64'h0);
        check_eq("adr_valP", bus.valP, 64'd4090);
        step(64'h0);
        check_eq("adr_stat", 64'(bus.stat), 64'd3);
        check_eq("adr_pc_hold", bus.pc, 64'd4090);

        pulse_reset();
        step(64'd4094);
        check_eq("edge_icode", 64'(bus.icode), 64'h2);
        check_eq("edge_rA", 64'(bus.rA), 64'h1);
        check_eq("edge_valP", bus.valP, 64'd4096);
        step(64'h0);
        check_eq("edge_stat", 64'(bus.stat), 64'd1);
        check_eq("edge_pc", bus.pc, 64'h0);
        check_eq("edge_retired", bus.retired, 64'd2);

        pulse_reset();
        step(64'h10000);
        check_eq("oorpc_icode", 64'(bus.icode), 64'h1);
        check_eq("oorpc_valP", bus.valP, 64'h10000);
        step(64'h0);
        check_eq("oorpc_stat", 64'(bus.stat), 64'd3);

        pulse_reset();
        check_eq("oor_load_dropped", 64'(bus.icode), 64'h3);
        step(64'd10);
        step(64'd12);
        step(64'd14);
        check_eq("mid_retired_pre", bus.retired, 64'd3);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pc", bus.pc, 64'h0);
        check_eq("mid_rst_stat", 64'(bus.stat), 64'd1);
        check_eq("mid_rst_retired", bus.retired, 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rerun_valC", bus.valC, 64'h1122334455667788);
        step(64'd10);
        check_eq("rerun_icode", 64'(bus.icode), 64'h2);
        check_eq("rerun_retired", bus.retired, 64'd1);

        pulse_reset();
        bus.load_en   = 1'b1;
        bus.load_addr = 64'h0;
        bus.load_data = 8'h00;
        bus.pc_next   = 64'd10;
        #1;
        check_eq("samecyc_before", 64'(bus.icode), 64'h3);
        @(posedge clk);
        #1;
        bus.load_en = 1'b0;
        check_eq("samecyc_pc", bus.pc, 64'd10);
        check_eq("samecyc_stat", 64'(bus.stat), 64'd1);
        pulse_reset();
        check_eq("samecyc_visible", 64'(bus.icode), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
